// File: rtl/instrument_switch_fader_pkg.sv
// Shared audio-path definitions: fader FSM state encoding and gain scaling constants.
package instrument_switch_fader_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_SWITCH   = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  localparam int DEFAULT_GAIN_W = 8;
  localparam int GAIN_UNITY     = 1 << DEFAULT_GAIN_W;

  // Unity gain for an arbitrary fraction width, used where GAIN_W is overridden.
  function automatic int unity_for(input int gain_w);
    return 1 << gain_w;
  endfunction

endpackage

// File: rtl/instrument_switch_fader_audio_gain_mul.sv
// Registered signed sample times unsigned gain, rescaled by the gain fraction width.
module audio_gain_mul #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [GAIN_W:0]   gain,
  output logic signed [DATA_W-1:0] result
);

  localparam int PW = DATA_W + GAIN_W + 2;

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] scaled;

  // Gain is unsigned, so it is zero-extended before joining the signed multiply.
  always_comb begin
    sample_ext = PW'(sample);
    gain_ext   = signed'(PW'(gain));
    product    = sample_ext * gain_ext;
    scaled     = product >>> GAIN_W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (en) begin
      result <= scaled[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/instrument_switch_fader.sv
// Click-free instrument change: fades the voice bank out, swaps the instrument index, fades back in.
module instrument_switch_fader
  import instrument_switch_fader_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = DEFAULT_GAIN_W,
  parameter int STEP      = 1,
  parameter int NUM_INSTR = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic        [7:0]        instr_code,
  input  logic                     sample_tick,
  input  logic signed [DATA_W-1:0] audio_in,
  output logic        [7:0]        active_instr,
  output logic        [GAIN_W:0]   gain,
  output logic signed [DATA_W-1:0] audio_out,
  output logic                     busy,
  output logic                     switch_done
);

  localparam logic [GAIN_W:0] UNITY  = (GAIN_W+1)'(unity_for(GAIN_W));
  localparam logic [GAIN_W:0] STEP_G = (GAIN_W+1)'(STEP);
  localparam logic [8:0]      NUM_CODES = 9'(NUM_INSTR);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [7:0]      pending;
  logic [GAIN_W:0] gain_nxt;
  logic [GAIN_W:0] gain_dec;
  logic [GAIN_W:0] gain_inc;
  logic            code_valid;
  logic            change;
  logic            done_nxt;

  assign code_valid = ({1'b0, instr_code} < NUM_CODES);
  assign change     = code_valid && (instr_code != pending);
  assign gain_dec   = (gain > STEP_G) ? (gain - STEP_G) : '0;
  assign gain_inc   = (gain < (UNITY - STEP_G)) ? (gain + STEP_G) : UNITY;
  assign busy       = (state != ST_IDLE);

  // A change during fade-in reverses the ramp from wherever the gain currently sits.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (change) begin
          state_nxt = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        if (gain == '0) begin
          state_nxt = ST_SWITCH;
        end else if (sample_tick) begin
          gain_nxt = gain_dec;
        end
      end
      ST_SWITCH: begin
        state_nxt = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (change) begin
          state_nxt = ST_FADE_OUT;
        end else if (gain == UNITY) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (sample_tick) begin
          gain_nxt = gain_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      pending      <= '0;
      active_instr <= '0;
      gain         <= UNITY;
      switch_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      gain        <= gain_nxt;
      switch_done <= done_nxt;
      if (change) begin
        pending <= instr_code;
      end
      if (state == ST_SWITCH) begin
        active_instr <= pending;
      end
    end
  end

  audio_gain_mul #(
    .DATA_W(DATA_W),
    .GAIN_W(GAIN_W)
  ) u_gain_mul (
    .clk    (clk),
    .reset  (reset),
    .en     (sample_tick),
    .sample (audio_in),
    .gain   (gain),
    .result (audio_out)
  );

endmodule

// File: tb/tb_instrument_switch_fader.sv
// Directed bench for instrument_switch_fader: fades, switches, reversal, invalid codes, mid-fade reset.
module tb_instrument_switch_fader;

  logic               clk;
  logic               reset;
  logic        [7:0]  instr_code;
  logic               sample_tick;
  logic signed [15:0] audio_in;
  logic        [7:0]  active_instr;
  logic        [8:0]  gain;
  logic signed [15:0] audio_out;
  logic               busy;
  logic               switch_done;

  int checks;
  int failures;
  int done_cnt;
  bit tick_seen;

  instrument_switch_fader dut (
    .clk          (clk),
    .reset        (reset),
    .instr_code   (instr_code),
    .sample_tick  (sample_tick),
    .audio_in     (audio_in),
    .active_instr (active_instr),
    .gain         (gain),
    .audio_out    (audio_out),
    .busy         (busy),
    .switch_done  (switch_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample strobe: one clock high out of every four, changed on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    tick_seen = sample_tick;
    if (switch_done) done_cnt++;
  endtask

  task automatic wait_gain(input logic [8:0] target, input string name, output int ticks);
    bit ok;
    ok = 1'b0;
    ticks = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (tick_seen) ticks++;
      if (gain == target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: gain=%0d required=%0d", name, gain, target);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: busy still high", name);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    instr_code = 8'd0;
    audio_in   = 16'sh4000;
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++;
    if (active_instr !== 8'd0) begin
      failures++; $display("[TB] FAIL reset_active: got %0d required 0", active_instr);
    end
    checks++;
    if (gain !== 9'd256) begin
      failures++; $display("[TB] FAIL reset_gain: got %0d required 256", gain);
    end
    checks++;
    if (busy !== 1'b0 || switch_done !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_flags: busy=%b done=%b required 0 0", busy, switch_done);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick_seen) break;
    end
    checks++;
    if (audio_out !== 16'sh4000) begin
      failures++; $display("[TB] FAIL reset_audio: got %h required 4000", audio_out);
    end
  endtask

  task automatic test_basic_switch();
    int ticks;
    int done_base;
    done_base = done_cnt;
    instr_code = 8'd3;
    step();
    checks++;
    if (busy !== 1'b1 || gain !== 9'd256) begin
      failures++; $display("[TB] FAIL switch_start: busy=%b gain=%0d required 1 256", busy, gain);
    end
    wait_gain(9'd0, "switch_fade_out", ticks);
    checks++;
    if (ticks != 256) begin
      failures++; $display("[TB] FAIL switch_out_ticks: got %0d required 256", ticks);
    end
    step();
    checks++;
    if (active_instr !== 8'd0) begin
      failures++; $display("[TB] FAIL switch_pre_swap: got %0d required 0", active_instr);
    end
    step();
    checks++;
    if (active_instr !== 8'd3) begin
      failures++; $display("[TB] FAIL switch_swap: got %0d required 3", active_instr);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick_seen) break;
    end
    checks++;
    if (audio_out !== 16'sh0000 || gain !== 9'd1) begin
      failures++; $display("[TB] FAIL switch_zero_audio: audio=%h gain=%0d required 0000 1", audio_out, gain);
    end
    wait_gain(9'd256, "switch_fade_in", ticks);
    checks++;
    if (ticks != 255) begin
      failures++; $display("[TB] FAIL switch_in_ticks: got %0d required 255 more", ticks);
    end
    wait_idle("switch_idle");
    repeat (10) step();
    checks++;
    if (done_cnt - done_base != 1) begin
      failures++; $display("[TB] FAIL switch_done_count: got %0d required 1", done_cnt - done_base);
    end
  endtask

  task automatic test_latest_wins();
    int ticks;
    int done_base;
    bit saw_two;
    done_base = done_cnt;
    saw_two = 1'b0;
    ticks = 0;
    instr_code = 8'd2;
    step();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (tick_seen) ticks++;
      if (ticks == 100) instr_code = 8'd5;
      if (gain == 9'd0) break;
    end
    checks++;
    if (ticks != 256) begin
      failures++; $display("[TB] FAIL latest_out_ticks: got %0d required 256", ticks);
    end
    for (int i = 0; i < 3000; i++) begin
      step();
      if (active_instr == 8'd2) saw_two = 1'b1;
      if (!busy) break;
    end
    repeat (4) step();
    checks++;
    if (active_instr !== 8'd5 || saw_two) begin
      failures++; $display("[TB] FAIL latest_active: got %0d saw_two=%b required 5 0", active_instr, saw_two);
    end
    checks++;
    if (done_cnt - done_base != 1) begin
      failures++; $display("[TB] FAIL latest_done_count: got %0d required 1", done_cnt - done_base);
    end
  endtask

  task automatic test_reverse();
    int ticks;
    int rev_ticks;
    int done_base;
    done_base = done_cnt;
    instr_code = 8'd1;
    wait_gain(9'd0, "reverse_first_out", ticks);
    wait_gain(9'd128, "reverse_half_in", ticks);
    audio_in   = 16'sh8000;
    instr_code = 8'd7;
    rev_ticks  = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick_seen) begin
        rev_ticks++;
        break;
      end
    end
    checks++;
    if (audio_out !== 16'shC000 || gain !== 9'd127 || busy !== 1'b1) begin
      failures++; $display("[TB] FAIL reverse_audio: audio=%h gain=%0d busy=%b required c000 127 1", audio_out, gain, busy);
    end
    audio_in = 16'sh4000;
    wait_gain(9'd0, "reverse_out", ticks);
    checks++;
    if (rev_ticks + ticks != 128) begin
      failures++; $display("[TB] FAIL reverse_out_ticks: got %0d required 128", rev_ticks + ticks);
    end
    wait_idle("reverse_idle");
    repeat (4) step();
    checks++;
    if (active_instr !== 8'd7 || done_cnt - done_base != 1) begin
      failures++; $display("[TB] FAIL reverse_result: active=%0d done=%0d required 7 1", active_instr, done_cnt - done_base);
    end
  endtask

  task automatic test_invalid();
    int done_base;
    instr_code = 8'd9;
    repeat (12) step();
    checks++;
    if (busy !== 1'b0 || active_instr !== 8'd7 || gain !== 9'd256) begin
      failures++; $display("[TB] FAIL invalid_idle: busy=%b active=%0d gain=%0d required 0 7 256", busy, active_instr, gain);
    end
    instr_code = 8'd7;
    repeat (6) step();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL invalid_pending_idle: busy=%b required 0", busy);
    end
    done_base = done_cnt;
    instr_code = 8'd2;
    repeat (20) step();
    instr_code = 8'd9;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL invalid_fade_busy: busy=%b required 1", busy);
    end
    wait_idle("invalid_idle");
    instr_code = 8'd2;
    repeat (8) step();
    checks++;
    if (busy !== 1'b0 || active_instr !== 8'd2 || done_cnt - done_base != 1) begin
      failures++; $display("[TB] FAIL invalid_fade_result: busy=%b active=%0d done=%0d required 0 2 1", busy, active_instr, done_cnt - done_base);
    end
  endtask

  task automatic test_reset_mid_fade();
    int ticks;
    int done_base;
    done_base = done_cnt;
    instr_code = 8'd4;
    wait_gain(9'd50, "midreset_fade", ticks);
    reset      = 1'b1;
    instr_code = 8'd0;
    step();
    checks++;
    if (busy !== 1'b0 || gain !== 9'd256 || active_instr !== 8'd0 || audio_out !== 16'sh0000 || switch_done !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_values: busy=%b gain=%0d active=%0d audio=%h done=%b required 0 256 0 0000 0", busy, gain, active_instr, audio_out, switch_done);
    end
    reset = 1'b0;
    repeat (12) step();
    checks++;
    if (busy !== 1'b0 || gain !== 9'd256 || done_cnt != done_base) begin
      failures++; $display("[TB] FAIL midreset_after: busy=%b gain=%0d pulses=%0d required 0 256 0", busy, gain, done_cnt - done_base);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    done_cnt   = 0;
    tick_seen  = 1'b0;
    reset      = 1'b1;
    instr_code = 8'd0;
    audio_in   = 16'sh4000;
    test_reset();
    test_basic_switch();
    test_latest_wins();
    test_reverse();
    test_invalid();
    test_reset_mid_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
